// File: rtl/muxn_seq.sv
// muxn_seq: N-to-1, WIDTH-bit multiplexer with a registered output and an
// internal selection sequencer (direct select, masked round-robin, hold).
// Optional switch counter output sw_cnt is built when MUXN_SEQ_SWCNT_EN is
// defined; without it the port and counter are absent.
module muxn_seq #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   d,
    input  logic [N-1:0]         en_mask,
    input  logic [1:0]           mode,
    input  logic [SELW-1:0]      sel_in,
    input  logic                 advance,
    output logic [WIDTH-1:0]     z,
    output logic                 z_valid,
    output logic [SELW-1:0]      sel_cur
`ifdef MUXN_SEQ_SWCNT_EN
    ,
    output logic [15:0]          sw_cnt
`endif
);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_RR     = 2'b01;

    logic [SELW-1:0] rr_sel;
    logic [SELW-1:0] sel_next;
    logic            sel_in_ok;
    logic            kill_valid;
    logic            valid_next;

    // Round-robin search: first enabled channel after sel_cur, wrapping mod N.
    // If nothing else is enabled the selection stays put.
    always_comb begin
        rr_sel = sel_cur;
        for (int k = N - 1; k >= 1; k--) begin
            int idx;
            idx = int'(sel_cur) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            // Walking from the farthest candidate down leaves the nearest one.
            if (en_mask[idx]) begin
                rr_sel = SELW'(idx);
            end
        end
    end

    // Next selection and validity for the current mode.
    always_comb begin
        sel_next   = sel_cur;
        kill_valid = 1'b0;
        sel_in_ok  = (int'(sel_in) < N);
        case (mode)
            MODE_DIRECT: begin
                if (sel_in_ok) begin
                    sel_next = sel_in;
                end else begin
                    kill_valid = 1'b1;
                end
            end
            MODE_RR: begin
                if (advance) begin
                    sel_next = rr_sel;
                end
            end
            default: begin
                sel_next = sel_cur;
            end
        endcase
        // An empty mask never marks sel_cur enabled, so validity drops here too.
        valid_next = en_mask[sel_next] & ~kill_valid;
    end

    // Output and selection registers; data is resampled every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_cur <= '0;
            z       <= '0;
            z_valid <= 1'b0;
        end else begin
            sel_cur <= sel_next;
            z       <= d[int'(sel_next)*WIDTH +: WIDTH];
            z_valid <= valid_next;
        end
    end

`ifdef MUXN_SEQ_SWCNT_EN
    // Saturating count of edges where the selection moves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_cnt <= '0;
        end else if ((sel_next != sel_cur) && (sw_cnt != 16'hFFFF)) begin
            sw_cnt <= sw_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_muxn_seq.sv
// Directed testbench for muxn_seq: a 4-channel byte instance covering reset,
// direct, round-robin, hold and mask behaviour, plus a 3-channel instance for
// the non-power-of-two select range and mod-N wrap.
module tb_muxn_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] d;
    logic [3:0]  en_mask;
    logic [1:0]  mode;
    logic [1:0]  sel_in;
    logic        advance;
    logic [7:0]  z;
    logic        z_valid;
    logic [1:0]  sel_cur;

    logic [11:0] d3;
    logic [2:0]  en_mask3;
    logic [1:0]  mode3;
    logic [1:0]  sel_in3;
    logic        advance3;
    logic [3:0]  z3;
    logic        z_valid3;
    logic [1:0]  sel_cur3;

`ifdef MUXN_SEQ_SWCNT_EN
    logic [15:0] sw_cnt;
    logic [15:0] sw_cnt3;
`endif

    int checks   = 0;
    int failures = 0;

    muxn_seq #(.WIDTH(8), .N(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .en_mask (en_mask),
        .mode    (mode),
        .sel_in  (sel_in),
        .advance (advance),
        .z       (z),
        .z_valid (z_valid),
        .sel_cur (sel_cur)
`ifdef MUXN_SEQ_SWCNT_EN
        ,
        .sw_cnt  (sw_cnt)
`endif
    );

    muxn_seq #(.WIDTH(4), .N(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d3),
        .en_mask (en_mask3),
        .mode    (mode3),
        .sel_in  (sel_in3),
        .advance (advance3),
        .z       (z3),
        .z_valid (z_valid3),
        .sel_cur (sel_cur3)
`ifdef MUXN_SEQ_SWCNT_EN
        ,
        .sw_cnt  (sw_cnt3)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [7:0] ez, input logic ev, input logic [1:0] es);
        check({tag, ".z"}, 32'(z), 32'(ez));
        check({tag, ".z_valid"}, 32'(z_valid), 32'(ev));
        check({tag, ".sel_cur"}, 32'(sel_cur), 32'(es));
    endtask

    task automatic check3(input string tag, input logic [3:0] ez, input logic ev, input logic [1:0] es);
        check({tag, ".z"}, 32'(z3), 32'(ez));
        check({tag, ".z_valid"}, 32'(z_valid3), 32'(ev));
        check({tag, ".sel_cur"}, 32'(sel_cur3), 32'(es));
    endtask

    initial begin
        d        = {8'h44, 8'h33, 8'h22, 8'h11};
        en_mask  = 4'hF;
        mode     = 2'b01;
        sel_in   = 2'd0;
        advance  = 1'b1;
        d3       = {4'hC, 4'hB, 4'hA};
        en_mask3 = 3'b111;
        mode3    = 2'b10;
        sel_in3  = 2'd0;
        advance3 = 1'b0;
        rst_n    = 1'b0;

        // Reset held for two edges while round-robin is requested.
        step();
        check4("rst_edge1", 8'h00, 1'b0, 2'd0);
        step();
        check4("rst_edge2", 8'h00, 1'b0, 2'd0);
`ifdef MUXN_SEQ_SWCNT_EN
        check("rst_sw_cnt", 32'(sw_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        step();
        check4("rr_after_release", 8'h22, 1'b1, 2'd1);

        // Direct select, then mask the selected channel.
        mode   = 2'b00;
        sel_in = 2'd2;
        step();
        check4("direct_sel2", 8'h33, 1'b1, 2'd2);
        en_mask = 4'hB;
        step();
        check4("direct_masked", 8'h33, 1'b0, 2'd2);

        // Round-robin over channels 1 and 3.
        en_mask = 4'b1010;
        sel_in  = 2'd1;
        step();
        check4("direct_sel1", 8'h22, 1'b1, 2'd1);
        mode    = 2'b01;
        advance = 1'b1;
        step();
        check4("rr_step1", 8'h44, 1'b1, 2'd3);
        step();
        check4("rr_step2", 8'h22, 1'b1, 2'd1);
        step();
        check4("rr_step3", 8'h44, 1'b1, 2'd3);
        step();
        check4("rr_step4", 8'h22, 1'b1, 2'd1);
        advance = 1'b0;
        step();
        check4("rr_no_advance", 8'h22, 1'b1, 2'd1);

        // Empty mask, then only channel 0 enabled: wrap from 1 to 0.
        advance = 1'b1;
        en_mask = 4'h0;
        step();
        check4("rr_empty_mask", 8'h22, 1'b0, 2'd1);
        en_mask = 4'h1;
        step();
        check4("rr_wrap_to_0", 8'h11, 1'b1, 2'd0);
        step();
        check4("rr_only_self", 8'h11, 1'b1, 2'd0);

        // Hold: selection frozen, data still tracked.
        mode    = 2'b00;
        sel_in  = 2'd3;
        en_mask = 4'hF;
        step();
        check4("direct_sel3", 8'h44, 1'b1, 2'd3);
        mode    = 2'b10;
        sel_in  = 2'd0;
        advance = 1'b1;
        step();
        check4("hold_ignore", 8'h44, 1'b1, 2'd3);
        d[31:24] = 8'h5A;
        sel_in   = 2'd1;
        advance  = 1'b0;
        step();
        check4("hold_data_track", 8'h5A, 1'b1, 2'd3);
        mode    = 2'b11;
        advance = 1'b1;
        sel_in  = 2'd2;
        step();
        check4("reserved_hold", 8'h5A, 1'b1, 2'd3);

        // Reset in the middle of a round-robin sweep.
        mode  = 2'b01;
        rst_n = 1'b0;
        step();
        check4("rst_mid_rr", 8'h00, 1'b0, 2'd0);
        rst_n = 1'b1;

        // Three-channel instance: out-of-range select and mod-3 wrap.
        mode3    = 2'b00;
        sel_in3  = 2'd2;
        mode     = 2'b10;
        step();
        check3("n3_direct_sel2", 4'hC, 1'b1, 2'd2);
        sel_in3 = 2'd3;
        step();
        check3("n3_sel_out_of_range", 4'hC, 1'b0, 2'd2);
        mode3    = 2'b01;
        advance3 = 1'b1;
        step();
        check3("n3_rr_wrap", 4'hA, 1'b1, 2'd0);
        en_mask3 = 3'b100;
        step();
        check3("n3_rr_skip", 4'hC, 1'b1, 2'd2);

`ifdef MUXN_SEQ_SWCNT_EN
        // Switch counter: three moves then two hold cycles.
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        en_mask = 4'hF;
        mode    = 2'b01;
        advance = 1'b1;
        step();
        step();
        step();
        mode = 2'b10;
        step();
        step();
        check("sw_cnt_three", 32'(sw_cnt), 32'd3);
        mode = 2'b01;
        for (int i = 0; i < 65540; i++) begin
            step();
        end
        check("sw_cnt_saturate", 32'(sw_cnt), 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
